crop_stream_ctrl: RTL and testbench

Crop sequencer between the incoming video AXI-Stream slave and the master-side output FIFO's write port. It tracks pixel column and row within each frame, selects the pixels inside a runtime-programmed crop window, and drives the FIFO's wr_en/data_in/last_in/user_in. It generates output SOF on the first kept pixel and EOL on the last kept pixel of each crop row. Back-pressure comes from the FIFO full flag.

---
 rtl/crop_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_crop_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crop_stream_ctrl.sv
// Crop sequencer: tracks column/row of an incoming video AXI-Stream frame and
// forwards only the pixels inside the latched crop window to the output FIFO.
module crop_stream_ctrl #(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_CNT_WIDTH   = 12
) (
  input  logic                     AXIS_ACLK,
  input  logic                     AXIS_ARESETN,
  input  logic                     enable,
  input  logic [C_CNT_WIDTH-1:0]   crop_x0,
  input  logic [C_CNT_WIDTH-1:0]   crop_y0,
  input  logic [C_CNT_WIDTH-1:0]   crop_w,
  input  logic [C_CNT_WIDTH-1:0]   crop_h,
  input  logic [C_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  input  logic                     S_AXIS_TLAST,
  input  logic                     S_AXIS_TUSER,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic [C_TDATA_WIDTH-1:0] fifo_data,
  output logic                     fifo_last,
  output logic                     fifo_user,
  output logic                     frame_done,
  output logic                     err_sof_early,
  output logic                     err_short_line,
  output logic                     err_cfg
);
  localparam int CW = C_CNT_WIDTH;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   WIDE_ONE = {{CW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, SKIP} state_t;
  state_t state, state_next;

  logic [CW-1:0] x, x_next, y, y_next;
  logic [CW-1:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
  logic [CW-1:0] cur_x, cur_y, eff_x0, eff_y0, eff_w, eff_h;
  logic [CW:0]   x_wide, y_wide, x_end, y_end;
  logic          acc, sof, sof_zero, pix;
  logic          in_win, crop_row, last_col, row_last, short_line;
  logic          done_next, early_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign S_AXIS_TREADY = AXIS_ARESETN & ~fifo_full;
  assign acc           = S_AXIS_TVALID & S_AXIS_TREADY;
  assign sof           = acc & S_AXIS_TUSER & enable;

  // A SOF beat is pixel (0,0) of the new frame and is judged against the
  // incoming config, since the registers only capture it at the clock edge.
  assign eff_x0 = sof ? crop_x0 : cfg_x0;
  assign eff_y0 = sof ? crop_y0 : cfg_y0;
  assign eff_w  = sof ? crop_w  : cfg_w;
  assign eff_h  = sof ? crop_h  : cfg_h;
  assign cur_x  = sof ? '0 : x;
  assign cur_y  = sof ? '0 : y;

  assign sof_zero = sof & ((eff_w == '0) | (eff_h == '0));
  assign pix      = (sof & ~sof_zero) | (acc & ~S_AXIS_TUSER & (state == ACTIVE));

  // Window ends are one bit wider so x0+w never wraps.
  assign x_wide   = {1'b0, cur_x};
  assign y_wide   = {1'b0, cur_y};
  assign x_end    = {1'b0, eff_x0} + {1'b0, eff_w};
  assign y_end    = {1'b0, eff_y0} + {1'b0, eff_h};
  assign crop_row = (y_wide >= {1'b0, eff_y0}) & (y_wide < y_end);
  assign in_win   = crop_row & (x_wide >= {1'b0, eff_x0}) & (x_wide < x_end);
  assign last_col = (x_wide + WIDE_ONE) == x_end;
  assign row_last = (y_wide + WIDE_ONE) == y_end;
  assign short_line = pix & S_AXIS_TLAST & crop_row & ((x_wide + WIDE_ONE) < x_end);

  assign fifo_wr_en = pix & in_win;
  assign fifo_data  = S_AXIS_TDATA;
  assign fifo_user  = (cur_x == eff_x0) & (cur_y == eff_y0);
  assign fifo_last  = in_win & (last_col | S_AXIS_TLAST);

  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    done_next  = 1'b0;
    early_next = acc & S_AXIS_TUSER & (state == ACTIVE);
    if (sof) begin
      state_next = sof_zero ? SKIP : ACTIVE;
      x_next     = '0;
      y_next     = '0;
    end else if (early_next) begin
      state_next = WAIT_SOF;
    end
    if (pix) begin
      if (S_AXIS_TLAST) begin
        x_next = '0;
        y_next = sat_inc(cur_y);
        if (row_last) begin
          state_next = SKIP;
          done_next  = 1'b1;
        end
      end else begin
        x_next = sat_inc(cur_x);
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state          <= WAIT_SOF;
      x              <= '0;
      y              <= '0;
      cfg_x0         <= '0;
      cfg_y0         <= '0;
      cfg_w          <= '0;
      cfg_h          <= '0;
      frame_done     <= 1'b0;
      err_sof_early  <= 1'b0;
      err_short_line <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      state          <= state_next;
      x              <= x_next;
      y              <= y_next;
      frame_done     <= done_next;
      err_sof_early  <= early_next;
      err_short_line <= short_line;
      err_cfg        <= sof_zero;
      if (sof) begin
        cfg_x0 <= crop_x0;
        cfg_y0 <= crop_y0;
        cfg_w  <= crop_w;
        cfg_h  <= crop_h;
      end
    end
  end
endmodule

// File: tb/tb_crop_stream_ctrl.sv
// Self-checking bench for crop_stream_ctrl: directed frames with literal
// expectations plus randomized frames checked cycle by cycle against a model.
module tb_crop_stream_ctrl;
  localparam int DW = 32;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [CW-1:0] crop_x0 = '0, crop_y0 = '0, crop_w = '0, crop_h = '0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, full = 1'b0;
  logic          tready, wr_en, f_last, f_user;
  logic [DW-1:0] f_data;
  logic          frame_done, err_sof_early, err_short_line, err_cfg;

  crop_stream_ctrl #(.C_TDATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .enable(enable),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .S_AXIS_TLAST(tlast), .S_AXIS_TUSER(tuser),
    .fifo_wr_en(wr_en), .fifo_full(full), .fifo_data(f_data),
    .fifo_last(f_last), .fifo_user(f_user),
    .frame_done(frame_done), .err_sof_early(err_sof_early),
    .err_short_line(err_short_line), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int log_d[$], log_l[$], log_u[$];
  int n_done, n_early, n_short, n_cfg, n_notready;
  bit rand_full = 1'b0;

  // Reference state: 0 = waiting for SOF, 1 = inside a crop frame, 2 = skipping
  int m_st, m_x, m_y, m_x0, m_y0, m_w, m_h;
  bit e_done, e_early, e_short, e_cfg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_full) full = ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin : cmp
    bit acc, nf, zero, pix, inw, crow, exp_wr;
    int px, py, ex0, ey0, ew, eh;
    if (!rst_n) begin
      m_st = 0; m_x = 0; m_y = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0;
      e_done = 0; e_early = 0; e_short = 0; e_cfg = 0;
      check("tready_in_reset", tready, 0);
      check("wr_en_in_reset", wr_en, 0);
      check("pulses_in_reset", {frame_done, err_sof_early, err_short_line, err_cfg}, 0);
    end else begin
      check("frame_done", frame_done, e_done);
      check("err_sof_early", err_sof_early, e_early);
      check("err_short_line", err_short_line, e_short);
      check("err_cfg", err_cfg, e_cfg);
      n_done += int'(frame_done); n_early += int'(err_sof_early);
      n_short += int'(err_short_line); n_cfg += int'(err_cfg);
      check("tready", tready, !full);
      if (!tready) n_notready++;

      acc  = tvalid && !full;
      nf   = acc && tuser && enable;
      ex0  = nf ? int'(crop_x0) : m_x0;
      ey0  = nf ? int'(crop_y0) : m_y0;
      ew   = nf ? int'(crop_w)  : m_w;
      eh   = nf ? int'(crop_h)  : m_h;
      px   = nf ? 0 : m_x;
      py   = nf ? 0 : m_y;
      zero = (ew == 0) || (eh == 0);
      pix  = acc && ((nf && !zero) || (m_st == 1 && !tuser));
      crow = (py >= ey0) && (py < ey0 + eh);
      inw  = crow && (px >= ex0) && (px < ex0 + ew);
      exp_wr = pix && inw;

      check("wr_en", wr_en, exp_wr);
      if (exp_wr && wr_en) begin
        check("fifo_data", f_data, tdata);
        check("fifo_last", f_last, (px == ex0 + ew - 1) || tlast);
        check("fifo_user", f_user, (px == ex0) && (py == ey0));
      end
      if (wr_en) begin
        log_d.push_back(int'(f_data)); log_l.push_back(int'(f_last)); log_u.push_back(int'(f_user));
      end

      e_early = acc && tuser && (m_st == 1);
      e_cfg   = nf && zero;
      e_short = pix && tlast && crow && (px < ex0 + ew - 1);
      e_done  = pix && tlast && (py == ey0 + eh - 1);

      if (nf) begin
        m_x0 = ex0; m_y0 = ey0; m_w = ew; m_h = eh;
        m_st = zero ? 2 : 1; m_x = 0; m_y = 0;
      end else if (e_early) begin
        m_st = 0;
      end
      if (pix) begin
        if (tlast) begin
          m_x = 0;
          m_y = (py < 4095) ? py + 1 : py;
          if (e_done) m_st = 2;
        end else begin
          m_x = (px < 4095) ? px + 1 : px;
        end
      end
    end
  end

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit l, input bit u);
    int n = 0;
    bit r;
    tdata = d; tlast = l; tuser = u; tvalid = 1'b1;
    do begin
      @(negedge clk); r = tready;
      @(posedge clk); #1; n++;
    end while (!r && n < 1000);
    if (!r) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got no handshake in %0d cycles", n);
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  // Short row ends early at short_x; sending stops before pixel (stop_x, stop_y).
  task automatic send_frame(input int fw, input int fh, input int short_row, input int short_x,
                            input int stop_x, input int stop_y, input bit rnd);
    bit l;
    for (int y = 0; y < fh; y++) begin
      for (int x = 0; x < fw; x++) begin
        if (y == stop_y && x == stop_x) return;
        l = (x == fw - 1) || (y == short_row && x == short_x);
        if (rnd && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        send_beat(rnd ? DW'($urandom) : DW'(y * fw + x), l, (x == 0) && (y == 0));
        if (l) break;
      end
    end
  endtask

  task automatic set_cfg(input int a, input int b, input int c, input int d);
    crop_x0 = CW'(a); crop_y0 = CW'(b); crop_w = CW'(c); crop_h = CW'(d);
  endtask

  task automatic clear_log();
    log_d.delete(); log_l.delete(); log_u.delete();
    n_done = 0; n_early = 0; n_short = 0; n_cfg = 0; n_notready = 0;
  endtask

  task automatic check_log(input string tag, input int ed[$], input int el[$], input int eu[$]);
    check({tag, "_write_count"}, log_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < log_d.size(); i++) begin
      check({tag, "_data"}, log_d[i], ed[i]);
      check({tag, "_last"}, log_l[i], el[i]);
      check({tag, "_user"}, log_u[i], eu[i]);
    end
  endtask

  initial begin
    int ed[$], el[$], eu[$];
    int snap, fw, fh, sr, sx, stx, sty;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 1: basic 8x4 frame, 2..4 x 1..2 window
    set_cfg(2, 1, 3, 2); clear_log();
    send_frame(8, 4, -1, -1, -1, -1, 0); idle(3);
    ed = '{10, 11, 12, 18, 19, 20}; el = '{0, 0, 1, 0, 0, 1}; eu = '{1, 0, 0, 0, 0, 0};
    check_log("basic", ed, el, eu);
    check("basic_done_count", n_done, 1);

    // 2: five cycles of FIFO full mid-frame
    clear_log();
    fork
      send_frame(8, 4, -1, -1, -1, -1, 0);
      begin
        repeat (10) @(posedge clk); #1 full = 1'b1;
        repeat (5) @(posedge clk); #1 full = 1'b0;
      end
    join
    idle(3);
    check_log("backpressure", ed, el, eu);
    check("backpressure_notready_cycles", n_notready, 5);

    // 3: SOF injected at (4,2)
    clear_log();
    send_frame(8, 4, -1, -1, 4, 2, 0);
    send_frame(8, 4, -1, -1, -1, -1, 0); idle(3);
    ed = '{10, 11, 12, 18, 19, 10, 11, 12, 18, 19, 20};
    el = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    eu = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    check_log("early_sof", ed, el, eu);
    check("early_sof_pulses", n_early, 1);
    check("early_sof_done_count", n_done, 1);

    // 4: crop_w changed mid-frame only applies from the next SOF
    clear_log();
    fork
      send_frame(8, 4, -1, -1, -1, -1, 0);
      begin repeat (5) @(posedge clk); #1 crop_w = CW'(5); end
    join
    send_frame(8, 4, -1, -1, -1, -1, 0); idle(3);
    ed = '{10, 11, 12, 18, 19, 20, 10, 11, 12, 13, 14, 18, 19, 20, 21, 22};
    el = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    eu = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_log("cfg_change", ed, el, eu);

    // 5: row 1 ends at x=3
    set_cfg(2, 1, 3, 2); clear_log();
    send_frame(8, 4, 1, 3, -1, -1, 0); idle(3);
    ed = '{10, 11, 18, 19, 20}; el = '{0, 1, 0, 0, 1}; eu = '{1, 0, 0, 0, 0};
    check_log("short_line", ed, el, eu);
    check("short_line_pulses", n_short, 1);
    check("short_line_done_count", n_done, 1);

    // 6: zero-height window, then reset mid-row
    set_cfg(2, 1, 3, 0); clear_log();
    send_frame(8, 4, -1, -1, -1, -1, 0); idle(3);
    check("zero_cfg_writes", log_d.size(), 0);
    check("zero_cfg_pulses", n_cfg, 1);
    check("zero_cfg_done_count", n_done, 0);
    set_cfg(2, 1, 3, 2); clear_log(); snap = 0;
    fork
      send_frame(8, 4, -1, -1, -1, -1, 0);
      begin
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_tready", tready, 0);
        check("async_reset_wr_en", wr_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap = log_d.size();
      end
    join
    idle(3);
    check("after_reset_no_writes", log_d.size(), snap);
    clear_log();
    send_frame(8, 4, -1, -1, -1, -1, 0); idle(3);
    ed = '{10, 11, 12, 18, 19, 20}; el = '{0, 0, 1, 0, 0, 1}; eu = '{1, 0, 0, 0, 0, 0};
    check_log("after_reset_frame", ed, el, eu);

    // Randomized frames, configs, gaps, back-pressure and protocol errors
    rand_full = 1'b1;
    for (int it = 0; it < 40; it++) begin
      enable = ($urandom_range(0, 9) != 0);
      set_cfg($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 8), $urandom_range(0, 5));
      fw  = $urandom_range(4, 10);
      fh  = $urandom_range(2, 6);
      sr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fh - 1) : -1;
      sx  = $urandom_range(0, fw - 2);
      stx = $urandom_range(0, fw - 1);
      sty = ($urandom_range(0, 4) == 0) ? $urandom_range(0, fh - 1) : -1;
      fork
        send_frame(fw, fh, sr, sx, stx, sty, 1);
        begin
          if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 crop_w = CW'($urandom_range(0, 8));
            crop_x0 = CW'($urandom_range(0, 9));
          end
        end
      join
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    rand_full = 1'b0;
    idle(5);
    full = 1'b0;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
